// File: rtl/bram_uart_dump_pkg.sv
// Shared constants for the BRAM-to-UART readout: FSM encoding and UART 8N1 framing.
package bram_uart_dump_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_LATCH = 3'd3;
  localparam logic [2:0] S_SEND  = 3'd4;
  localparam logic [2:0] S_NEXT  = 3'd5;

  localparam logic UART_START_BIT       = 1'b0;
  localparam logic UART_STOP_BIT        = 1'b1;
  localparam int   UART_FRAME_LEN       = 10;
  // 100 MHz system clock, 115200 baud
  localparam int   UART_CLK_DIV_DEFAULT = 868;

endpackage

// File: rtl/bram_uart_dump_if.sv
// BRAM read port as seen by the dump engine (master) and the BRAM read side (slave).
interface bram_uart_dump_if #(
  parameter int NB_ADDR = 15,
  parameter int NB_DATA = 32
);
  logic [NB_ADDR-1:0] o_read_addr;
  logic               o_read_enable;
  logic [NB_DATA-1:0] i_read_data;

  modport master (output o_read_addr, output o_read_enable, input i_read_data);
  modport slave  (input o_read_addr, input o_read_enable, output i_read_data);
endinterface

// File: rtl/bram_uart_dump_uart_tx.sv
// 8N1 UART transmitter; o_ready rises in the last stop-bit cycle so frames can run back-to-back.
module bram_uart_dump_uart_tx
  import bram_uart_dump_pkg::*;
#(
  parameter int CLK_DIV = UART_CLK_DIV_DEFAULT
) (
  input  logic       clock,
  input  logic       i_reset,
  input  logic       i_valid,
  input  logic [7:0] i_byte,
  output logic       o_ready,
  output logic       o_tx
);
  localparam int                 NB_BAUD   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [NB_BAUD-1:0] BAUD_LAST = NB_BAUD'(CLK_DIV - 1);
  localparam logic [3:0]         BIT_LAST  = 4'(UART_FRAME_LEN - 1);

  logic [UART_FRAME_LEN-1:0] r_shift;
  logic [NB_BAUD-1:0]        r_baud;
  logic [3:0]                r_bit;
  logic                      r_active;
  logic                      w_bit_end;
  logic                      w_frame_end;

  assign w_bit_end   = r_active && (r_baud == BAUD_LAST);
  assign w_frame_end = w_bit_end && (r_bit == BIT_LAST);
  assign o_ready     = !r_active || w_frame_end;
  // Shift register idles all-ones, so the line stays high between frames
  assign o_tx        = r_shift[0];

  always_ff @(posedge clock) begin
    if (i_reset) begin
      r_shift  <= '1;
      r_baud   <= '0;
      r_bit    <= '0;
      r_active <= 1'b0;
    end else if (i_valid && o_ready) begin
      r_shift  <= {UART_STOP_BIT, i_byte, UART_START_BIT};
      r_baud   <= '0;
      r_bit    <= '0;
      r_active <= 1'b1;
    end else if (w_frame_end) begin
      r_shift  <= '1;
      r_baud   <= '0;
      r_bit    <= '0;
      r_active <= 1'b0;
    end else if (w_bit_end) begin
      r_shift  <= {1'b1, r_shift[UART_FRAME_LEN-1:1]};
      r_baud   <= '0;
      r_bit    <= r_bit + 4'd1;
    end else if (r_active) begin
      r_baud   <= r_baud + 1'b1;
    end
  end

endmodule

// File: rtl/bram_uart_dump.sv
// Walks the capture BRAM from address 0 to DEPTH-1 and streams each word over UART,
// least-significant byte first.
module bram_uart_dump
  import bram_uart_dump_pkg::*;
#(
  parameter int NB_ADDR = 15,
  parameter int NB_DATA = 32,
  parameter int DEPTH   = 2048,
  parameter int CLK_DIV = UART_CLK_DIV_DEFAULT
) (
  input  logic                  clock,
  input  logic                  i_reset,
  input  logic                  i_start,
  bram_uart_dump_if.master      bram,
  output logic                  o_tx,
  output logic                  o_busy,
  output logic                  o_done
);
  localparam int                 NBYTES    = NB_DATA / 8;
  localparam int                 NB_BIDX   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [NB_BIDX-1:0] LAST_BYTE = NB_BIDX'(NBYTES - 1);
  localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(DEPTH - 1);

  logic [2:0]         r_state;
  logic [NB_ADDR-1:0] r_addr;
  logic [NB_BIDX-1:0] r_byte_idx;
  logic [NB_DATA-1:0] r_word;
  logic               r_busy;
  logic               r_done;

  logic [NB_BIDX-1:0] w_next_idx;
  logic               w_uart_valid;
  logic [7:0]         w_uart_byte;
  logic               w_uart_ready;

  function automatic logic [7:0] byte_of(input logic [NB_DATA-1:0] word,
                                         input logic [NB_BIDX-1:0] idx);
    return 8'(word >> {idx, 3'b000});
  endfunction

  assign w_next_idx = r_byte_idx + 1'b1;

  // Byte 0 goes straight from the BRAM output during LATCH so the first start
  // bit lands the cycle after; later bytes come from the latched word.
  assign w_uart_valid = (r_state == S_LATCH) ||
                        ((r_state == S_SEND) && w_uart_ready && (r_byte_idx != LAST_BYTE));
  assign w_uart_byte  = (r_state == S_LATCH) ? bram.i_read_data[7:0]
                                             : byte_of(r_word, w_next_idx);

  assign bram.o_read_addr   = r_addr;
  assign bram.o_read_enable = (r_state == S_FETCH);
  assign o_busy             = r_busy;
  assign o_done             = r_done;

  always_ff @(posedge clock) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_byte_idx <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state <= S_FETCH;
            r_addr  <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_FETCH: r_state <= S_WAIT;
        S_WAIT:  r_state <= S_LATCH;
        S_LATCH: begin
          r_byte_idx <= '0;
          r_state    <= S_SEND;
        end
        S_SEND: begin
          if (w_uart_ready) begin
            if (r_byte_idx == LAST_BYTE) r_state <= S_NEXT;
            else r_byte_idx <= w_next_idx;
          end
        end
        S_NEXT: begin
          if (r_addr == LAST_ADDR) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_addr  <= '0;
            r_state <= S_IDLE;
          end else begin
            r_addr  <= r_addr + 1'b1;
            r_state <= S_FETCH;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (r_state == S_LATCH) r_word <= bram.i_read_data;
  end

  bram_uart_dump_uart_tx #(
    .CLK_DIV (CLK_DIV)
  ) u_uart_tx (
    .clock   (clock),
    .i_reset (i_reset),
    .i_valid (w_uart_valid),
    .i_byte  (w_uart_byte),
    .o_ready (w_uart_ready),
    .o_tx    (o_tx)
  );

endmodule

// File: tb/tb_bram_uart_dump.sv
// Directed bench for bram_uart_dump with a 1-cycle-latency BRAM model and a per-cycle line log.
module tb_bram_uart_dump;
  localparam int NB_ADDR = 4;
  localparam int NB_DATA = 32;
  localparam int DEPTH   = 4;
  localparam int CLK_DIV = 4;
  localparam int LOG     = 700;
  localparam int RUN     = 690;

  logic clock = 1'b0;
  logic i_reset = 1'b1;
  logic i_start = 1'b0;
  logic o_tx, o_busy, o_done;

  bram_uart_dump_if #(.NB_ADDR(NB_ADDR), .NB_DATA(NB_DATA)) bif ();

  bram_uart_dump #(
    .NB_ADDR (NB_ADDR),
    .NB_DATA (NB_DATA),
    .DEPTH   (DEPTH),
    .CLK_DIV (CLK_DIV)
  ) dut (
    .clock   (clock),
    .i_reset (i_reset),
    .i_start (i_start),
    .bram    (bif),
    .o_tx    (o_tx),
    .o_busy  (o_busy),
    .o_done  (o_done)
  );

  always #5 clock = ~clock;

  logic [31:0] mem [0:3];
  initial begin
    mem[0] = 32'h11223344;
    mem[1] = 32'hA5A5A5A5;
    mem[2] = 32'h00000000;
    mem[3] = 32'hFFFFFFFF;
  end

  always @(posedge clock) begin
    if (bif.o_read_enable) bif.i_read_data <= mem[bif.o_read_addr[1:0]];
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int   t0 = 0;
  logic logging = 1'b0;
  logic       tx_log   [0:LOG-1];
  logic       busy_log [0:LOG-1];
  logic       done_log [0:LOG-1];
  logic       en_log   [0:LOG-1];
  logic [3:0] addr_log [0:LOG-1];

  always @(negedge clock) begin
    if (logging && (cyc - t0) >= 0 && (cyc - t0) < LOG) begin
      tx_log[cyc - t0]   <= o_tx;
      busy_log[cyc - t0] <= o_busy;
      done_log[cyc - t0] <= o_done;
      en_log[cyc - t0]   <= bif.o_read_enable;
      addr_log[cyc - t0] <= bif.o_read_addr;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // r[8] = frame well formed (start 0, stop 1, every bit held CLK_DIV cycles), r[7:0] = data
  task automatic decode(input int s, output logic [8:0] r);
    logic v;
    r = 9'h100;
    for (int i = 0; i < 10; i++) begin
      v = tx_log[s + CLK_DIV*i];
      for (int c = 1; c < CLK_DIV; c++)
        if (tx_log[s + CLK_DIV*i + c] !== v) r[8] = 1'b0;
      if (i == 0 && v !== 1'b0) r[8] = 1'b0;
      if (i == 9 && v !== 1'b1) r[8] = 1'b0;
      if (i >= 1 && i <= 8) r[i-1] = v;
    end
  endtask

  task automatic run_dump(input bit extra_start);
    @(posedge clock); #1;
    i_start = 1'b1;
    t0 = cyc;
    logging = 1'b1;
    @(posedge clock); #1;
    i_start = 1'b0;
    repeat (RUN) begin
      @(posedge clock); #1;
      i_start = (extra_start && cyc == t0 + 300) ? 1'b1 : 1'b0;
    end
    i_start = 1'b0;
    logging = 1'b0;
  endtask

  task automatic check_run(input string p);
    logic [8:0] r;
    int  n_done, first_done, n_en;
    bit  gap_ok;
    check({p, "_busy_before"}, 32'(busy_log[0]), 32'd0);
    check({p, "_busy_T1"},     32'(busy_log[1]), 32'd1);
    check({p, "_tx_T3_idle"},  32'(tx_log[3]),   32'd1);
    check({p, "_tx_T4_start"}, 32'(tx_log[4]),   32'd0);
    for (int w = 0; w < 4; w++)
      for (int k = 0; k < 4; k++) begin
        decode(4 + 164*w + 40*k, r);
        check($sformatf("%s_w%0d_b%0d", p, w, k), 32'(r), 32'({1'b1, 8'(mem[w] >> (8*k))}));
      end
    for (int w = 0; w < 3; w++) begin
      gap_ok = 1'b1;
      for (int c = 0; c < 4; c++)
        if (tx_log[164 + 164*w + c] !== 1'b1) gap_ok = 1'b0;
      check($sformatf("%s_gap%0d", p, w), 32'(gap_ok), 32'd1);
    end
    n_done = 0;
    first_done = -1;
    n_en = 0;
    for (int i = 0; i < LOG; i++) begin
      if (done_log[i] === 1'b1) begin
        if (first_done < 0) first_done = i;
        n_done++;
      end
      if (en_log[i] === 1'b1) begin
        if (n_en < 4) begin
          check($sformatf("%s_en%0d_addr", p, n_en), 32'(addr_log[i]), 32'(n_en));
          check($sformatf("%s_en%0d_cycle", p, n_en), 32'(i), 32'(1 + 164*n_en));
        end
        n_en++;
      end
    end
    check({p, "_done_count"}, 32'(n_done), 32'd1);
    check({p, "_done_cycle"}, 32'(first_done), 32'd657);
    check({p, "_busy_last"},  32'(busy_log[656]), 32'd1);
    check({p, "_busy_after"}, 32'(busy_log[657]), 32'd0);
    check({p, "_en_count"},   32'(n_en), 32'd4);
  endtask

  int errs;

  initial begin
    // reset, with a start request colliding with it: reset wins
    repeat (3) @(posedge clock);
    #1 i_start = 1'b1;
    @(posedge clock); #1;
    i_start = 1'b0;
    check("start_vs_reset_busy", 32'(o_busy), 32'd0);
    i_reset = 1'b0;
    @(negedge clock);
    check("rst_tx",   32'(o_tx),   32'd1);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_addr", 32'(bif.o_read_addr), 32'd0);
    errs = 0;
    repeat (50) begin
      @(negedge clock);
      if (o_tx !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0 ||
          bif.o_read_addr !== 4'd0 || bif.o_read_enable !== 1'b0) errs++;
    end
    check("reset_idle_50", 32'(errs), 32'd0);

    run_dump(1'b0);
    check_run("dump");

    // reset in the middle of byte 2 of word 1 (0xA5), while bit 3 (=0) is on the line
    @(posedge clock); #1;
    i_start = 1'b1;
    t0 = cyc;
    @(posedge clock); #1;
    i_start = 1'b0;
    repeat (263) @(posedge clock);
    #1;
    check("midframe_tx_before", 32'(o_tx), 32'd0);
    i_reset = 1'b1;
    @(posedge clock); #1;
    check("midframe_tx_after",   32'(o_tx),   32'd1);
    check("midframe_busy_after", 32'(o_busy), 32'd0);
    check("midframe_done_after", 32'(o_done), 32'd0);
    i_reset = 1'b0;
    errs = 0;
    repeat (30) begin
      @(negedge clock);
      if (o_done !== 1'b0 || o_tx !== 1'b1 || o_busy !== 1'b0) errs++;
    end
    check("midframe_quiet", 32'(errs), 32'd0);

    run_dump(1'b1);
    check_run("rerun_busy_start");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bram_uart_dump.md
# bram_uart_dump

Readout stage downstream of the capture BRAM. Once a capture has completed, it walks the BRAM read port from address 0 to DEPTH-1 and streams every stored word out of the board over a UART TX line (8N1, least-significant byte first). The host can therefore retrieve the captured FIR samples without the on-chip logic analyser. The block owns the BRAM read address and read enable while busy, and idles with the line high otherwise.

## Interface
Parameters:
- NB_ADDR, 15: BRAM read address width.
- NB_DATA, 32: BRAM read data width; must be a multiple of 8.
- DEPTH, 2048: number of words dumped per run; must be ≤ 2^NB_ADDR.
- CLK_DIV, 868: clock cycles per UART bit (100 MHz / 115200); must be ≥ 2.

Ports:
- clock, in, 1: system clock; all logic on the rising edge.
- i_reset, in, 1: synchronous, active-high reset.
- i_start, in, 1: one-cycle start request (driven from the capture-full indication through the edge detector).
- i_read_data, in, NB_DATA: BRAM read data.
- o_read_addr, out, NB_ADDR: BRAM read address.
- o_read_enable, out, 1: BRAM read enable; high only in FETCH.
- o_tx, out, 1: UART serial output; idles high.
- o_busy, out, 1: high from the cycle after an accepted i_start until the cycle o_done pulses.
- o_done, out, 1: one-cycle pulse after the stop bit of the last byte of word DEPTH-1.

## Operation
- FSM states: IDLE, FETCH, WAIT, LATCH, SEND, NEXT.
- IDLE:
  - o_read_addr holds 0.
  - i_start=1 → FETCH; address counter ← 0.
- FETCH: o_read_enable=1, o_read_addr=current address; → WAIT.
- WAIT: one wait state that tolerates BRAM read latency ≤ 2; → LATCH.
- LATCH: word register ← i_read_data; byte index ← 0; → SEND.
- SEND:
  - Start uart_tx with byte[byte index], where byte 0 = bits [7:0].
  - When the frame completes, if byte index < NB_DATA/8-1, increment the byte index and start the next frame immediately.
  - After the last byte → NEXT.
- NEXT:
  - If address == DEPTH-1: pulse o_done, clear o_busy → IDLE; the address counter does not wrap.
  - Otherwise increment the address → FETCH.
- UART frame: start bit 0, 8 data bits LSB first, stop bit 1; each bit held exactly CLK_DIV cycles.
- i_start is ignored while o_busy=1. No queuing, no restart.
- i_start on the same cycle as i_reset: reset wins.
- Reset values: o_tx=1, o_busy=0, o_done=0, o_read_enable=0, o_read_addr=0, state IDLE, all counters 0.

## Timing
- i_start at cycle T:
  - FETCH at T+1; o_busy=1 from T+1.
  - LATCH at T+3.
  - First start bit on o_tx from T+4.
- Frame length is 10·CLK_DIV cycles. Frames within one word are back-to-back with no idle gap.
- Between words, o_tx stays high for 4 cycles: NEXT, FETCH, WAIT, LATCH.
- Total run length: DEPTH·(4 + (NB_DATA/8)·10·CLK_DIV) cycles, ±1 cycle for the final NEXT/done.
- o_done is asserted in the cycle after the last stop bit period ends. o_busy=0 in that same cycle.
- Reset mid-frame: o_tx=1 at the next edge, even if that truncates the frame. Any partial word is discarded.
- Widths:
  - Baud counter: $clog2(CLK_DIV) bits; counts 0..CLK_DIV-1.
  - Bit index: 4 bits (0..9).
  - Byte index: $clog2(NB_DATA/8) bits, minimum 1.

## Structure
- Shared package holds:
  - FSM state encoding localparams.
  - UART frame constants: start bit value, stop bit value, frame length 10.
  - Default CLK_DIV for 100 MHz / 115200.
- Sub-module uart_tx:
  - Interface: i_valid/i_byte in, o_ready/o_tx out.
  - Internals: 10-bit shift register plus baud counter.
  - o_ready is high in the same cycle the stop bit period ends, so that back-to-back frames are possible.
- The top module only instantiates bram_uart_dump and connects its read port to the BRAM read side.

## Test plan
Tests use CLK_DIV=4, DEPTH=4, NB_DATA=32, and a behavioural BRAM model with 1-cycle latency.

- Reset idle: reset, then idle 50 cycles → o_tx=1, o_busy=0, o_done=0, o_read_addr=0 throughout.
- Single dump: BRAM = {0x11223344, 0xA5A5A5A5, 0x00000000, 0xFFFFFFFF}; pulse i_start → UART decoder receives bytes 44 33 22 11 A5 A5 A5 A5 00 00 00 00 FF FF FF FF. o_done pulses exactly once, at cycle T+4·(4+160)+1.
- Bit timing: check word 0 → start bit low for exactly 4 cycles; byte 0x44 appears LSB first; no idle gap between bytes within a word; 4 idle-high cycles between words.
- Start while busy: pulse i_start again mid-run → run length and byte stream are unchanged, and only one o_done pulse occurs.
- Reset mid-frame: assert i_reset during byte 2 of word 1 → o_tx=1 and o_busy=0 at the next edge, with no o_done. A following i_start dumps from address 0 again.
- Address sweep: monitor o_read_addr/o_read_enable → enable pulses exactly 4 times, at addresses 0, 1, 2, 3, with no access beyond DEPTH-1.
